// File: rtl/fp16_mat_pkg.sv
// rtl/fp16_mat_pkg.sv - shared constants, state encoding and matrix element helpers for the fp16 3x3 multiply
package fp16_mat_pkg;

    localparam int ELEM_W = 16;
    localparam int MAT_N  = 3;
    localparam int PMAT_W = MAT_N * MAT_N * ELEM_W;

    localparam logic [ELEM_W-1:0] FP16_ZERO = 16'h0000;
    localparam logic [ELEM_W-1:0] FP16_ONE  = 16'h3C00;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    // Row-major packing: element [0][0] occupies the most significant slice.
    function automatic logic [ELEM_W-1:0] get_elem(input logic [PMAT_W-1:0] m,
                                                   input logic [1:0] r, input logic [1:0] c);
        int idx;
        idx = int'(r) * MAT_N + int'(c);
        return m[PMAT_W-1-idx*ELEM_W -: ELEM_W];
    endfunction

    function automatic logic [PMAT_W-1:0] set_elem(input logic [PMAT_W-1:0] m,
                                                   input logic [1:0] r, input logic [1:0] c,
                                                   input logic [ELEM_W-1:0] v);
        logic [PMAT_W-1:0] res;
        int idx;
        res = m;
        idx = int'(r) * MAT_N + int'(c);
        res[PMAT_W-1-idx*ELEM_W -: ELEM_W] = v;
        return res;
    endfunction

endpackage

// File: rtl/mat3_idx_cnt.sv
// rtl/mat3_idx_cnt.sv - nested i/j/k index counter walking all 27 multiply-accumulate terms
module mat3_idx_cnt
    import fp16_mat_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step,
    output logic [1:0] i,
    output logic [1:0] j,
    output logic [1:0] k,
    output logic       elem_last,
    output logic       all_last
);

    localparam logic [1:0] LAST = 2'(MAT_N - 1);

    assign elem_last = (k == LAST);
    assign all_last  = (i == LAST) && (j == LAST) && (k == LAST);

    // k is innermost (dot-product term), then column j, then row i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step) begin
            if (k != LAST) begin
                k <= k + 2'd1;
            end else begin
                k <= '0;
                if (j != LAST) begin
                    j <= j + 2'd1;
                end else begin
                    j <= '0;
                    i <= (i == LAST) ? 2'd0 : i + 2'd1;
                end
            end
        end
    end

endmodule

// File: rtl/fp16_mat3_mul_seq.sv
// rtl/fp16_mat3_mul_seq.sv - sequencer sharing one fp16 multiplier and one adder across a 3x3 matrix multiply
module fp16_mat3_mul_seq
    import fp16_mat_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int N      = 3,
    localparam int MAT_W  = N * N * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [MAT_W-1:0]  mat_a,
    input  logic [MAT_W-1:0]  mat_b,
    output logic              busy,
    output logic              done,
    output logic [MAT_W-1:0]  mat_c,
    output logic              ovf_flag,
    output logic              nan_flag,
    output logic              prec_flag,
    output logic [DATA_W-1:0] mul_a,
    output logic [DATA_W-1:0] mul_b,
    input  logic [DATA_W-1:0] mul_p,
    input  logic              mul_ovf,
    input  logic              mul_nan,
    input  logic              mul_prec,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    input  logic [DATA_W-1:0] add_s
);

    state_t            state;
    logic [MAT_W-1:0]  a_q;
    logic [MAT_W-1:0]  b_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] prod_q;
    logic [1:0]        i, j, k;
    logic              elem_last, all_last;
    logic              clr, step;

    assign busy = (state != IDLE);
    // abort in the DONE cycle withdraws the pulse in that same cycle.
    assign done = (state == DONE) && !abort;
    assign clr  = (state == IDLE) && start;
    assign step = (state == ACC) && !abort;

    mat3_idx_cnt u_idx (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .step      (step),
        .i         (i),
        .j         (j),
        .k         (k),
        .elem_last (elem_last),
        .all_last  (all_last)
    );

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        add_a = '0;
        add_b = '0;
        if (state == MUL) begin
            mul_a = get_elem(a_q, i, k);
            mul_b = get_elem(b_q, k, j);
        end
        if (state == ACC) begin
            add_a = acc;
            add_b = prod_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= FP16_ZERO;
            prod_q    <= '0;
            mat_c     <= '0;
            ovf_flag  <= 1'b0;
            nan_flag  <= 1'b0;
            prec_flag <= 1'b0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_q       <= mat_a;
                    b_q       <= mat_b;
                    acc       <= FP16_ZERO;
                    ovf_flag  <= 1'b0;
                    nan_flag  <= 1'b0;
                    prec_flag <= 1'b0;
                    state     <= MUL;
                end
                MUL: begin
                    prod_q    <= mul_p;
                    ovf_flag  <= ovf_flag | mul_ovf;
                    nan_flag  <= nan_flag | mul_nan;
                    prec_flag <= prec_flag | mul_prec;
                    state     <= ACC;
                end
                ACC: begin
                    if (elem_last) begin
                        mat_c <= set_elem(mat_c, i, j, add_s);
                        acc   <= FP16_ZERO;
                    end else begin
                        acc   <= add_s;
                    end
                    state <= all_last ? DONE : MUL;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_mat3_mul_seq.sv
// tb/tb_fp16_mat3_mul_seq.sv - directed self-checking bench with behavioural fp16 multiplier and adder
module tb_fp16_mat3_mul_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [143:0] mat_a, mat_b, mat_c;
    logic         busy, done, ovf_flag, nan_flag, prec_flag;
    logic [15:0]  mul_a, mul_b, mul_p, add_a, add_b, add_s;
    logic         mul_ovf, mul_nan, mul_prec;

    int checks   = 0;
    int failures = 0;

    fp16_mat3_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mat_a(mat_a), .mat_b(mat_b), .busy(busy), .done(done), .mat_c(mat_c),
        .ovf_flag(ovf_flag), .nan_flag(nan_flag), .prec_flag(prec_flag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .mul_ovf(mul_ovf), .mul_nan(mul_nan), .mul_prec(mul_prec),
        .add_a(add_a), .add_b(add_b), .add_s(add_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) for (int n = 0; n < e; n++) r = r * 2.0;
        else        for (int n = 0; n < -e; n++) r = r / 2.0;
        return r;
    endfunction

    function automatic bit is_nan(input logic [15:0] h);
        return (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
    endfunction

    function automatic bit is_inf(input logic [15:0] h);
        return (h[14:10] == 5'd31) && (h[9:0] == 10'd0);
    endfunction

    function automatic real to_real(input logic [15:0] h);
        real r;
        if (h[14:10] == 5'd0) r = real'(h[9:0]) * pow2(-24);
        else                  r = real'(1024 + int'(h[9:0])) * pow2(int'(h[14:10]) - 25);
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] to_fp16(input real r);
        logic s;
        real  a;
        int   m;
        s = (r < 0.0);
        a = s ? -r : r;
        if (a == 0.0) return 16'h0000;
        if (a >= 65520.0) return {s, 15'h7C00};
        for (int e = 30; e >= 1; e--) begin
            if (a >= pow2(e - 15)) begin
                m = $rtoi(a / pow2(e - 25) + 0.5);
                if (m >= 2048) return (e == 30) ? {s, 15'h7C00} : {s, 5'(e + 1), 10'd0};
                return {s, 5'(e), m[9:0]};
            end
        end
        m = $rtoi(a * pow2(24) + 0.5);
        if (m >= 1024) return {s, 5'd1, 10'd0};
        return {s, 5'd0, m[9:0]};
    endfunction

    // {product, ovf, nan, prec}
    function automatic logic [18:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p;
        real         x;
        if (is_nan(a) || is_nan(b) ||
            (is_inf(a) && b[14:0] == 15'd0) || (is_inf(b) && a[14:0] == 15'd0))
            return {16'h7E00, 3'b010};
        if (is_inf(a) || is_inf(b)) return {a[15] ^ b[15], 15'h7C00, 3'b000};
        x = to_real(a) * to_real(b);
        p = to_fp16(x);
        if (is_inf(p)) return {p, 3'b101};
        return {p, 2'b00, to_real(p) != x};
    endfunction

    function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
        if (is_nan(a) || is_nan(b)) return 16'h7E00;
        if (is_inf(a) && is_inf(b)) return (a[15] == b[15]) ? a : 16'h7E00;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        return to_fp16(to_real(a) + to_real(b));
    endfunction

    always_comb begin
        {mul_p, mul_ovf, mul_nan, mul_prec} = fmul(mul_a, mul_b);
        add_s = fadd(add_a, add_b);
    end

    function automatic logic [143:0] fill(input logic [15:0] v);
        logic [143:0] m;
        for (int n = 0; n < 9; n++) m[143-16*n -: 16] = v;
        return m;
    endfunction

    function automatic logic [143:0] put(input logic [143:0] m, input int r, input int c,
                                         input logic [15:0] v);
        logic [143:0] t;
        t = m;
        t[143-16*(3*r+c) -: 16] = v;
        return t;
    endfunction

    function automatic logic [15:0] elem(input logic [143:0] m, input int r, input int c);
        return m[143-16*(3*r+c) -: 16];
    endfunction

    task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts an operation at the next rising edge (T) and watches cycles T+1..T+70.
    task automatic run_op(input logic [143:0] a, input logic [143:0] b,
                          output int done_cyc, output int done_cnt, output int busy_bad);
        done_cyc = -1;
        done_cnt = 0;
        busy_bad = 0;
        mat_a = a;
        mat_b = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mat_a = ~a;
        mat_b = ~b;
        for (int n = 1; n <= 70; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = n;
            end
            if (busy !== (n <= 55)) busy_bad++;
        end
    endtask

    logic [143:0] ident, twos, ones, ma, mb, exp_c;
    logic [15:0]  e;
    int           dcyc, dcnt, bbad;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mat_a = '0;
        mat_b = '0;
        ident = fill(16'h0000);
        for (int n = 0; n < 3; n++) ident = put(ident, n, n, 16'h3C00);
        twos = fill(16'h4000);
        ones = fill(16'h3C00);

        #23;
        chk("reset_mat_c", mat_c, 144'd0);
        chk("reset_status", {busy, done, ovf_flag, nan_flag, prec_flag}, 5'b0);
        chk("reset_operands", {mul_a, mul_b, add_a, add_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(ident, twos, dcyc, dcnt, bbad);
        chk("ident_mat_c", mat_c, fill(16'h4000));
        chk("ident_done_cycle", dcyc, 55);
        chk("ident_done_count", dcnt, 1);
        chk("ident_flags", {ovf_flag, nan_flag, prec_flag}, 3'b000);

        run_op(ones, ones, dcyc, dcnt, bbad);
        chk("ones_mat_c", mat_c, fill(16'h4200));
        chk("ones_busy_window", bbad, 0);
        chk("ones_done_cycle", dcyc, 55);

        ma = put(ones, 0, 0, 16'h7BFF);
        mb = put(ones, 0, 0, 16'h7BFF);
        run_op(ma, mb, dcyc, dcnt, bbad);
        chk("ovf_flag_held", ovf_flag, 1'b1);
        chk("ovf_c00", elem(mat_c, 0, 0), 16'h7C00);
        chk("ovf_c01", elem(mat_c, 0, 1), 16'h7BFF);
        chk("ovf_c11", elem(mat_c, 1, 1), 16'h4200);

        mb = put(ones, 1, 2, 16'h7E00);
        run_op(ones, mb, dcyc, dcnt, bbad);
        chk("nan_flag", nan_flag, 1'b1);
        chk("nan_ovf_cleared", ovf_flag, 1'b0);
        chk("nan_c00", elem(mat_c, 0, 0), 16'h4200);
        for (int r = 0; r < 3; r++) begin
            e = 16'h0000;
            for (int q = 0; q < 3; q++) e = fadd(e, fmul(elem(ones, r, q), elem(mb, q, 2)) >> 3);
            chk($sformatf("nan_c%0d2_model", r), elem(mat_c, r, 2), e);
            chk($sformatf("nan_c%0d2_hand", r), elem(mat_c, r, 2), 16'h7E00);
        end

        exp_c = put(mat_c, 0, 0, 16'h4000);
        mat_a = ident;
        mat_b = twos;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
            if (n == 5) begin
                mat_a = ones;
                start = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (n == 10) abort = 1'b1;
            if (n == 11) begin
                chk("abort_busy_low", busy, 1'b0);
                abort = 1'b0;
            end
        end
        chk("abort_no_done", dcnt, 0);
        chk("abort_mat_c", mat_c, exp_c);
        chk("abort_flags", {ovf_flag, nan_flag, prec_flag}, 3'b000);

        mat_a = ones;
        mat_b = ones;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 20; n++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mat_c", mat_c, 144'd0);
        chk("midrst_status", {busy, done, ovf_flag, nan_flag, prec_flag}, 5'b0);
        chk("midrst_operands", {mul_a, mul_b, add_a, add_b}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(ident, twos, dcyc, dcnt, bbad);
        chk("postrst_done_cycle", dcyc, 55);
        chk("postrst_mat_c", mat_c, fill(16'h4000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_mat3_mul_seq.md
Name: fp16_mat3_mul_seq

Overview:
- Sequencer for a 3x3 half-precision matrix multiply, C = A x B.
- Time-multiplexes one shared combinational fp16 multiplier (float_multi) and one shared combinational fp16 adder over all 27 multiply-accumulate terms.
- Sits between the matrix-op issue logic (start/done handshake) and the shared fp16 arithmetic units. Both units are external and driven through ports.
- Also collects sticky exception flags for the whole operation.

Parameters:
- DATA_W, 16, element width (fp16: sign, 5-bit exponent, 10-bit fraction).
- N, 3, matrix dimension. Only 3 is supported.
- MAT_W, N*N*DATA_W (144), packed matrix width. Derived; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  operation request; sampled only in IDLE.
- abort  in  1  cancel the running operation.
- mat_a  in  MAT_W  matrix A, row-major, element [0][0] in bits [143:128].
- mat_b  in  MAT_W  matrix B, same packing as mat_a.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; mat_c valid.
- mat_c  out  MAT_W  result matrix C, same packing.
- ovf_flag  out  1  sticky OR of multiplier overflow over the run.
- nan_flag  out  1  sticky OR of multiplier NaN over the run.
- prec_flag  out  1  sticky OR of multiplier precisionLost over the run.
- mul_a  out  16  multiplier operand 1.
- mul_b  out  16  multiplier operand 2.
- mul_p  in  16  multiplier result.
- mul_ovf  in  1  multiplier overflow flag.
- mul_nan  in  1  multiplier NaN flag.
- mul_prec  in  1  multiplier precisionLost flag.
- add_a  out  16  adder operand 1 (accumulator).
- add_b  out  16  adder operand 2 (registered product).
- add_s  in  16  adder sum.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE; i, j, k, acc and prod_q clear to 0.
  - mat_c = 0; busy = 0; done = 0; all flags 0; mul_a/mul_b/add_a/add_b = 0.
- States: IDLE, MUL, ACC, DONE. busy = (state != IDLE).
- IDLE:
  - On start=1: latch mat_a and mat_b into internal copies; clear i, j, k to 0; set acc = 16'h0000; clear all three sticky flags. Go to MUL.
  - mat_c is not cleared on start; it keeps the previous result until overwritten element by element.
- MUL:
  - mul_a = A[i][k], mul_b = B[k][j], taken from the latched copies.
  - Register prod_q <= mul_p.
  - Sticky update: each flag |= its corresponding mul_* input.
  - Go to ACC.
- ACC:
  - add_a = acc, add_b = prod_q.
  - If k < 2: acc <= add_s; k <= k+1.
  - If k == 2: C[i][j] <= add_s; acc <= 0; k <= 0; j <= j+1. When j wraps from 2 to 0, i <= i+1.
  - Go to MUL, except when i=2, j=2, k=2: go to DONE.
- DONE: done = 1 for exactly this cycle; next state IDLE.
- Operand outputs: mul_a/mul_b are 0 outside MUL; add_a/add_b are 0 outside ACC.
- Latency:
  - start sampled at edge T.
  - MUL/ACC occupy 54 cycles.
  - done is high in cycle T+55.
  - Next start is accepted from cycle T+56.
- start while busy: ignored, no effect on the run.
- abort:
  - When busy: next state IDLE at the next edge. No done pulse.
  - Flags keep their values. Elements of mat_c already written stay written.
  - abort has priority over state advance, including in DONE, where it suppresses the done pulse.
  - In IDLE, abort is ignored, and abort with start together: abort is ignored and start is taken.
- Reset mid-operation: immediate return to IDLE with all reset values. No done pulse.
- mat_a/mat_b may change freely after the start cycle; only the latched copies are used.
- No special-casing of zero, inf or NaN: the arithmetic units' results are accumulated verbatim. Flags report only multiplier exceptions.

Decomposition:
- Package fp16_mat_pkg:
  - constants FP16_ZERO=16'h0000, FP16_ONE=16'h3C00, MAT_N=3, ELEM_W=16.
  - state enum {IDLE, MUL, ACC, DONE}.
  - functions for row-major element pack/unpack at index [r][c].
- One sub-module, mat3_idx_cnt: the i/j/k nested counter.
  - Inputs: clr, step.
  - Outputs: i, j, k, elem_last (k==2), all_last (i=j=k=2).
- The FSM and datapath registers stay in the top module.

Test Plan:
- Identity x all-2.0: A = identity (3C00 on diagonal, 0000 elsewhere), B = all 16'h4000 → mat_c all 16'h4000; done exactly at T+55; all flags 0.
- All-ones x all-ones: A = B = all 16'h3C00 → every element 16'h4200 (3.0); busy high T+1..T+55.
- Overflow: A[0][0] = B[0][0] = 16'h7BFF, rest 16'h3C00 → ovf_flag=1 at done and held through IDLE; flag cleared by the next start.
- NaN: B[1][2] = 16'h7E00 → nan_flag=1. Bench models float_multi and the adder; C[i][2] for each i is checked against the bench adder/multiplier models.
- Abort: abort at T+10 → busy=0 at T+11, no done pulse. mat_c holds old contents except C[0][0], which was already written at T+6. A start pulsed at T+5 during the run has no effect.
- Reset mid-run: rst_n low at T+20 → outputs go to reset values asynchronously. A new start after release completes normally in 55 cycles.
